// File: rtl/hdmi_src_arbiter.sv
// Two-input HDMI source arbiter: per-input vsync presence detection, auto/manual
// source selection, and frame-aligned switching with mute during the changeover.
module hdmi_src_arbiter #(
  parameter int TIMEOUT       = 2000000,
  parameter int STABLE_FRAMES = 4,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       rdy0,
  input  logic       rdy1,
  input  logic       vsync0,
  input  logic       vsync1,
  input  logic       out_vsync,
  input  logic       mode,
  input  logic       man_sel,
  output logic       sel,
  output logic       mute,
  output logic       valid0,
  output logic       valid1,
  output logic [7:0] switch_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(STABLE_FRAMES + 1);
  localparam int SW = $clog2(SETTLE_FRAMES + 1);

  localparam logic [CW-1:0] CYC_MAX  = CW'(TIMEOUT);
  localparam logic [FW-1:0] FRM_MAX  = FW'(STABLE_FRAMES);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    WAIT_EDGE = 2'd2,
    SETTLE    = 2'd3
  } state_t;

  logic [1:0]    rdy_in, vs_in;
  logic [1:0]    vs_q, vs_d;
  logic [1:0]    vld_q, vld_d;
  logic [1:0]    rise, loss, valid;
  logic [CW-1:0] cyc_q [2];
  logic [CW-1:0] cyc_d [2];
  logic [FW-1:0] frm_q [2];
  logic [FW-1:0] frm_d [2];

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          pend_q, pend_d;
  logic          mute_q, mute_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [SW-1:0] set_q, set_d;
  logic          ov_q, ov_d;
  logic          ov_rise;

  logic          ref_sel;
  logic          tgt_vld;
  logic          tgt;

  // Presence detectors: loss (timeout or decoder not ready) masks valid immediately
  always_comb begin
    rdy_in = {rdy1, rdy0};
    vs_in  = {vsync1, vsync0};
    vs_d   = vs_in;
    rise   = '0;
    loss   = '0;
    valid  = '0;
    vld_d  = '0;
    for (int i = 0; i < 2; i++) begin
      rise[i]  = vs_in[i] & ~vs_q[i];
      loss[i]  = (cyc_q[i] == CYC_MAX) | ~rdy_in[i];
      cyc_d[i] = cyc_q[i];
      if (rise[i]) begin
        cyc_d[i] = '0;
      end else if (cyc_q[i] != CYC_MAX) begin
        cyc_d[i] = cyc_q[i] + CW'(1);
      end
      frm_d[i] = frm_q[i];
      if (loss[i]) begin
        frm_d[i] = '0;
      end else if (rise[i] && (frm_q[i] != FRM_MAX)) begin
        frm_d[i] = frm_q[i] + FW'(1);
      end
      vld_d[i] = ~loss[i] & (frm_d[i] == FRM_MAX);
      valid[i] = vld_q[i] & ~loss[i];
    end
  end

  // Auto mode holds whichever input is current; in IDLE input 0 wins a tie
  always_comb begin
    case (state_q)
      IDLE:    ref_sel = 1'b0;
      ACTIVE:  ref_sel = sel_q;
      default: ref_sel = pend_q;
    endcase
    tgt_vld = 1'b0;
    tgt     = ref_sel;
    if (!mode) begin
      if (valid[ref_sel]) begin
        tgt_vld = 1'b1;
        tgt     = ref_sel;
      end else if (valid[~ref_sel]) begin
        tgt_vld = 1'b1;
        tgt     = ~ref_sel;
      end
    end else if (valid[man_sel]) begin
      tgt_vld = 1'b1;
      tgt     = man_sel;
    end
  end

  assign ov_d    = out_vsync;
  assign ov_rise = out_vsync & ~ov_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    mute_d  = mute_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    case (state_q)
      IDLE: begin
        mute_d = 1'b1;
        if (tgt_vld) begin
          pend_d  = tgt;
          state_d = WAIT_EDGE;
        end
      end
      ACTIVE: begin
        mute_d = 1'b0;
        if (!tgt_vld) begin
          mute_d  = 1'b1;
          state_d = IDLE;
        end else if (tgt != sel_q) begin
          pend_d  = tgt;
          mute_d  = 1'b1;
          state_d = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        mute_d = 1'b1;
        if (!tgt_vld) begin
          state_d = IDLE;
        end else if (tgt != pend_q) begin
          pend_d = tgt;
        end else if (ov_rise) begin
          sel_d = pend_q;
          if (pend_q != sel_q) begin
            cnt_d = cnt_q + 8'd1;
          end
          set_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        mute_d = 1'b1;
        if (!tgt_vld) begin
          state_d = IDLE;
        end else if (tgt != sel_q) begin
          pend_d  = tgt;
          state_d = WAIT_EDGE;
        end else if (ov_rise) begin
          if (set_q == SET_LAST) begin
            mute_d  = 1'b0;
            state_d = ACTIVE;
          end else begin
            set_d = set_q + SW'(1);
          end
        end
      end
      default: begin
        mute_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q    <= '0;
      vld_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        cyc_q[i] <= '0;
        frm_q[i] <= '0;
      end
      state_q <= IDLE;
      sel_q   <= 1'b0;
      pend_q  <= 1'b0;
      mute_q  <= 1'b1;
      cnt_q   <= '0;
      set_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      vs_q    <= vs_d;
      vld_q   <= vld_d;
      for (int i = 0; i < 2; i++) begin
        cyc_q[i] <= cyc_d[i];
        frm_q[i] <= frm_d[i];
      end
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      mute_q  <= mute_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      ov_q    <= ov_d;
    end
  end

  assign sel        = sel_q;
  assign mute       = mute_q;
  assign valid0     = valid[0];
  assign valid1     = valid[1];
  assign switch_cnt = cnt_q;

endmodule
